// File: rtl/as_pack.sv
// Shared constants for the as_* core: GPIO sizing and the GPIO register map.
//   nr_gpios        - number of GPIO pins on the chip
//   gpio_addr_width - byte-address width of the GPIO register window
//   GPIO_*_IDX      - register index (addr[5:3]) of each GPIO register
//   gpio_reg_e      - named register indices for decode
//   gpio_be_mask()  - expands 8 byte enables into a 64-bit bit mask
package as_pack;

  localparam int unsigned nr_gpios        = 8;
  localparam int unsigned gpio_addr_width = 6;

  localparam int unsigned GPIO_DOUT_IDX  = 0;
  localparam int unsigned GPIO_DIR_IDX   = 1;
  localparam int unsigned GPIO_DIN_IDX   = 2;
  localparam int unsigned GPIO_IEN_IDX   = 3;
  localparam int unsigned GPIO_ISTAT_IDX = 4;

  typedef enum logic [2:0] {
    GpioRegDout  = 3'(GPIO_DOUT_IDX),
    GpioRegDir   = 3'(GPIO_DIR_IDX),
    GpioRegDin   = 3'(GPIO_DIN_IDX),
    GpioRegIen   = 3'(GPIO_IEN_IDX),
    GpioRegIstat = 3'(GPIO_ISTAT_IDX)
  } gpio_reg_e;

  function automatic logic [63:0] gpio_be_mask(input logic [7:0] be);
    return {{8{be[7]}}, {8{be[6]}}, {8{be[5]}}, {8{be[4]}},
            {8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/as_gpio_sync.sv
// Input path for the GPIO pins: 2-flop synchroniser followed by a history flop
// used for rising-edge detection.
//   clk_i  - core clock
//   rst_i  - synchronous reset, active-high
//   pins_i - raw (asynchronous) pin values
//   din_o  - synchronised pin values (second flop)
//   rise_o - 1 where the synchronised value went 0 -> 1 since the previous cycle
module as_gpio_sync #(
  parameter int unsigned NR_GPIOS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NR_GPIOS-1:0] pins_i,
  output logic [NR_GPIOS-1:0] din_o,
  output logic [NR_GPIOS-1:0] rise_o
);

  logic [NR_GPIOS-1:0] sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign din_o  = sync2_q;
  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/as_gpio_ctrl.sv
// Memory-mapped GPIO controller on the data-memory bus.
//   clk_i, rst_i        - core clock, synchronous active-high reset
//   req_i, we_i         - one-cycle bus request, 1 = write
//   addr_i, be_i        - byte address (register = addr[5:3]), write byte enables
//   wdata_i / rdata_o   - write data / registered read data (0 unless ack_o)
//   ack_o, err_o        - completion one cycle after req_i; err_o on unmapped address
//   gpio_io             - pins, driven from DOUT where DIR = 1, else high-Z
//   cs_o                - one-cycle strobe with ack_o on every DOUT write with any be_i set
//   irq_o               - registered level interrupt |(IRQ_STAT & IRQ_EN)
module as_gpio_ctrl
  import as_pack::*;
#(
  parameter int unsigned NR_GPIOS = nr_gpios,
  parameter int unsigned ADDR_W   = gpio_addr_width,
  parameter int unsigned DATA_W   = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                ack_o,
  output logic                err_o,
  inout  wire  [NR_GPIOS-1:0] gpio_io,
  output logic                cs_o,
  output logic                irq_o
);

  logic [NR_GPIOS-1:0] dout_q, dout_d, dir_q, dir_d, ien_q, ien_d, istat_q, istat_d;
  logic [NR_GPIOS-1:0] istat_clr, din, rise, wmask, wdata_g;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ack_q, ack_d, err_q, err_d, cs_q, cs_d, irq_q, irq_d;
  logic [63:0]         mask_full;
  logic [2:0]          idx;

  // Low address bits and unused data bits are ignored by design.
  logic unused_bits;
  assign unused_bits = ^{addr_i, wdata_i};

  assign idx       = addr_i[5:3];
  assign mask_full = gpio_be_mask(8'(be_i));
  assign wmask     = mask_full[NR_GPIOS-1:0];
  assign wdata_g   = wdata_i[NR_GPIOS-1:0];

  as_gpio_sync #(
    .NR_GPIOS (NR_GPIOS)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pins_i (gpio_io),
    .din_o  (din),
    .rise_o (rise)
  );

  for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pin
    assign gpio_io[g] = dir_q[g] ? dout_q[g] : 1'bz;
  end

  always_comb begin
    dout_d    = dout_q;
    dir_d     = dir_q;
    ien_d     = ien_q;
    istat_clr = '0;
    rdata_d   = '0;
    ack_d     = req_i;
    err_d     = 1'b0;
    cs_d      = 1'b0;
    if (req_i) begin
      case (idx)
        GpioRegDout: begin
          if (we_i) begin
            dout_d = (dout_q & ~wmask) | (wdata_g & wmask);
            cs_d   = |be_i;
          end else begin
            rdata_d = DATA_W'(dout_q);
          end
        end
        GpioRegDir: begin
          if (we_i) dir_d = (dir_q & ~wmask) | (wdata_g & wmask);
          else      rdata_d = DATA_W'(dir_q);
        end
        GpioRegDin: begin
          if (!we_i) rdata_d = DATA_W'(din);
        end
        GpioRegIen: begin
          if (we_i) ien_d = (ien_q & ~wmask) | (wdata_g & wmask);
          else      rdata_d = DATA_W'(ien_q);
        end
        GpioRegIstat: begin
          if (we_i) istat_clr = wdata_g & wmask;
          else      rdata_d   = DATA_W'(istat_q);
        end
        default: err_d = 1'b1;
      endcase
    end
    // A new edge wins over a same-cycle clear.
    istat_d = (istat_q & ~istat_clr) | (rise & ien_q);
    irq_d   = |(istat_q & ien_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q  <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      istat_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      istat_q <= istat_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign cs_o    = cs_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_as_gpio_ctrl.sv
module tb_as_gpio_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [5:0]  addr = '0;
  logic [7:0]  be = '0;
  logic [63:0] wdata = '0;
  logic [63:0] rdata;
  logic        ack, err, cs, irq;
  wire  [7:0]  gpio;
  logic [7:0]  tb_drv = '0;
  logic [7:0]  tb_oe = '0;

  int n_checks = 0;
  int n_pass = 0;

  logic        c_ack, c_err, c_cs, c_irq;
  logic [63:0] c_rdata;
  logic [7:0]  c_pins;

  for (genvar g = 0; g < 8; g++) begin : g_tbpin
    assign gpio[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
  end

  always #5 clk = ~clk;

  as_gpio_ctrl #(
    .NR_GPIOS (8),
    .ADDR_W   (6),
    .DATA_W   (64)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .be_i    (be),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ack_o   (ack),
    .err_o   (err),
    .gpio_io (gpio),
    .cs_o    (cs),
    .irq_o   (irq)
  );

  // One transaction: request at a negedge, outputs captured just after the acking edge,
  // pins captured at the negedge of the ack cycle.
  task automatic bus(input logic w, input logic [5:0] a, input logic [7:0] b,
                     input logic [63:0] d);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(posedge clk); #1;
    c_ack = ack; c_err = err; c_cs = cs; c_irq = irq; c_rdata = rdata;
    @(negedge clk);
    c_pins = gpio;
    req = 1'b0; we = 1'b0; be = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({ack, err, cs, irq} !== 4'b0000 || rdata !== 64'd0)
      $display("FAIL reset_outputs: got ack/err/cs/irq=%b rdata=%h, expected 0000 and 0",
               {ack, err, cs, irq}, rdata);
    else n_pass++;
    bus(1'b0, 6'h10, 8'h00, 64'd0);
    n_checks++;
    if ({c_ack, c_err} !== 2'b10 || c_rdata !== 64'd0)
      $display("FAIL reset_din_read: got ack/err=%b rdata=%h, expected 10 and 0",
               {c_ack, c_err}, c_rdata);
    else n_pass++;
    // With DIR = 0 the bench alone drives the pins; DIN must follow it exactly.
    tb_drv = 8'hA5; tb_oe = 8'hFF;
    repeat (3) @(negedge clk);
    bus(1'b0, 6'h10, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'hA5)
      $display("FAIL reset_pins_highz: got DIN=%h expected a5", c_rdata);
    else n_pass++;
    tb_oe = '0; tb_drv = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_dout_cs();
    bus(1'b1, 6'h08, 8'h01, 64'hFF);
    bus(1'b1, 6'h00, 8'h01, 64'h80);
    n_checks++;
    if ({c_ack, c_cs, c_err} !== 3'b110)
      $display("FAIL dout_cs_pulse: got ack/cs/err=%b expected 110", {c_ack, c_cs, c_err});
    else n_pass++;
    n_checks++;
    if (c_pins !== 8'h80) $display("FAIL dout_pins: got %h expected 80", c_pins);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({ack, cs} !== 2'b00 || rdata !== 64'd0)
      $display("FAIL dout_cs_drop: got ack/cs=%b rdata=%h expected 00 and 0", {ack, cs}, rdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 6'h00; be = 8'h01; wdata = 64'h11;
    @(posedge clk); #1; seen[2] = cs;
    @(negedge clk); // same value again, must still pulse
    @(posedge clk); #1; seen[1] = cs;
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = '0;
    @(posedge clk); #1; seen[0] = cs;
    n_checks++;
    if (seen !== 3'b110) $display("FAIL b2b_cs: got cs sequence %b expected 110", seen);
    else n_pass++;
    n_checks++;
    if (gpio !== 8'h11) $display("FAIL b2b_pins: got %h expected 11", gpio);
    else n_pass++;
  endtask

  task automatic test_be_mask();
    bus(1'b1, 6'h00, 8'hFF, 64'h05);
    bus(1'b1, 6'h00, 8'h02, 64'h1234);
    n_checks++;
    if (c_cs !== 1'b1) $display("FAIL be_mask_cs: got %b expected 1", c_cs);
    else n_pass++;
    bus(1'b0, 6'h00, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'h05) $display("FAIL be_mask_dout: got %h expected 05", c_rdata);
    else n_pass++;
  endtask

  task automatic test_irq_flow();
    logic [3:0] irq_seq;
    bus(1'b1, 6'h08, 8'h01, 64'h00);
    bus(1'b1, 6'h18, 8'h01, 64'h01);
    bus(1'b1, 6'h20, 8'h01, 64'hFF);
    repeat (3) @(negedge clk);
    tb_drv = 8'h01; tb_oe = 8'h01;
    for (int e = 3; e >= 0; e--) begin
      @(posedge clk); #1; irq_seq[e] = irq;
    end
    n_checks++;
    if (irq_seq !== 4'b0001) $display("FAIL irq_latency: got irq over edges 1..4 %b expected 0001", irq_seq);
    else n_pass++;
    bus(1'b0, 6'h10, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'h01) $display("FAIL irq_din: got %h expected 01", c_rdata);
    else n_pass++;
    bus(1'b0, 6'h20, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'h01) $display("FAIL irq_stat: got %h expected 01", c_rdata);
    else n_pass++;
    bus(1'b1, 6'h20, 8'h01, 64'h01);
    @(posedge clk); #1;
    n_checks++;
    if ({c_irq, irq} !== 2'b10)
      $display("FAIL irq_clear: got irq at ack/after=%b expected 10", {c_irq, irq});
    else n_pass++;
  endtask

  task automatic test_w1c_race();
    @(negedge clk); tb_drv = 8'h00;
    repeat (4) @(negedge clk);
    tb_drv = 8'h01;
    @(posedge clk);
    @(posedge clk);
    // The rise reaches IRQ_STAT on the very edge that samples this clear.
    bus(1'b1, 6'h20, 8'h01, 64'h01);
    bus(1'b0, 6'h20, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'h01) $display("FAIL w1c_race: got IRQ_STAT %h expected 01", c_rdata);
    else n_pass++;
    bus(1'b1, 6'h20, 8'h01, 64'hFF);
    bus(1'b0, 6'h20, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'h00) $display("FAIL w1c_plain: got IRQ_STAT %h expected 00", c_rdata);
    else n_pass++;
    bus(1'b1, 6'h18, 8'h01, 64'h00);
    tb_oe = '0; tb_drv = '0;
  endtask

  task automatic test_unmapped();
    bus(1'b0, 6'h30, 8'h00, 64'd0);
    n_checks++;
    if ({c_ack, c_err, c_cs} !== 3'b110 || c_rdata !== 64'd0)
      $display("FAIL unmapped_read: got ack/err/cs=%b rdata=%h expected 110 and 0",
               {c_ack, c_err, c_cs}, c_rdata);
    else n_pass++;
    bus(1'b1, 6'h38, 8'hFF, 64'hFF);
    n_checks++;
    if ({c_ack, c_err, c_cs} !== 3'b110)
      $display("FAIL unmapped_write: got ack/err/cs=%b expected 110", {c_ack, c_err, c_cs});
    else n_pass++;
    bus(1'b0, 6'h00, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'h05) $display("FAIL unmapped_nochange: got DOUT %h expected 05", c_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 6'h00; be = 8'hFF; wdata = 64'hAA; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ack, cs} !== 2'b00) $display("FAIL rst_mid_ack: got ack/cs=%b expected 00", {ack, cs});
    else n_pass++;
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = '0; rst = 1'b0;
    bus(1'b0, 6'h00, 8'h00, 64'd0);
    n_checks++;
    if (c_rdata !== 64'h00) $display("FAIL rst_mid_dout: got DOUT %h expected 00", c_rdata);
    else n_pass++;
  endtask

  // Randomised traffic against a reference model. Pins reach DIN two edges after
  // being sampled, and an edge seen on DIN sets IRQ_STAT one edge later.
  task automatic test_random();
    logic [7:0] m_dout, m_dir, m_ien, m_istat, p, mask, clr, rise, din;
    logic [7:0] ph[$];
    logic [2:0] idx;
    logic       e_ack, e_err, e_cs, e_irq;
    logic [63:0] e_rdata;
    int sz;
    int errs = 0;
    m_dout = '0; m_dir = '0; m_ien = '0; m_istat = '0;
    ph = '{8'h00, 8'h00, 8'h00};
    @(negedge clk); rst = 1'b1; tb_oe = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tb_oe  = (i == 0) ? 8'h00 : ~m_dir;
      tb_drv = 8'($urandom);
      if (i == 0) begin
        req = 1'b1; we = 1'b1; idx = 3'd1; be = 8'h01;
      end else begin
        req = ($urandom_range(0, 3) != 0);
        we  = 1'($urandom);
        idx = 3'($urandom_range(0, 7));
        if (we && idx == 3'd1) idx = 3'd0;
        be  = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      end
      addr  = {idx, 3'($urandom)};
      wdata = {$urandom, $urandom};
      sz    = ph.size();
      p     = (m_dout & m_dir) | (tb_drv & tb_oe);
      din   = ph[sz-2];
      rise  = ph[sz-2] & ~ph[sz-3] & m_ien;
      mask  = be[0] ? 8'hFF : 8'h00;
      clr   = '0;
      e_ack = req;
      e_err = req && idx >= 3'd5;
      e_cs  = req && we && idx == 3'd0 && be != 8'h00;
      e_irq = |(m_istat & m_ien);
      e_rdata = '0;
      if (req && !we) begin
        case (idx)
          3'd0: e_rdata = {56'd0, m_dout};
          3'd1: e_rdata = {56'd0, m_dir};
          3'd2: e_rdata = {56'd0, din};
          3'd3: e_rdata = {56'd0, m_ien};
          3'd4: e_rdata = {56'd0, m_istat};
          default: e_rdata = '0;
        endcase
      end
      if (req && we) begin
        case (idx)
          3'd0: m_dout = (m_dout & ~mask) | (wdata[7:0] & mask);
          3'd1: m_dir  = (m_dir & ~mask) | (wdata[7:0] & mask);
          3'd3: m_ien  = (m_ien & ~mask) | (wdata[7:0] & mask);
          3'd4: clr    = wdata[7:0] & mask;
          default: ;
        endcase
      end
      m_istat = (m_istat & ~clr) | rise;
      ph.push_back(p);
      if (ph.size() > 4) void'(ph.pop_front());
      @(posedge clk); #1;
      n_checks++;
      if ({ack, err, cs, irq} !== {e_ack, e_err, e_cs, e_irq} || rdata !== e_rdata) begin
        if (errs < 10)
          $display("FAIL random[%0d]: got ack/err/cs/irq=%b rdata=%h expected %b rdata=%h",
                   i, {ack, err, cs, irq}, rdata, {e_ack, e_err, e_cs, e_irq}, e_rdata);
        errs++;
      end else n_pass++;
      @(negedge clk);
      req = 1'b0;
    end
    tb_oe = '0;
  endtask

  initial begin
    test_reset();
    test_dout_cs();
    test_back_to_back();
    test_be_mask();
    test_irq_flow();
    test_w1c_race();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/as_gpio_ctrl.md
Name: as_gpio_ctrl

Overview:
Memory-mapped GPIO controller between the core's data-memory bus and the chip-level gpio_io pins.
It holds output, direction, input-sync and edge-interrupt registers. It emits a one-cycle cs_o strobe on every accepted write to the output register, and the integration benches use that strobe to sample gpio_io.
It is instantiated in as_top_mem next to the data memory.

Parameters:
NR_GPIOS, 8 (as_pack::nr_gpios), number of GPIO pins; legal range 1..64.
ADDR_W, 6, byte-address width of the register window.
DATA_W, 64, bus data width (RV64).

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous reset, active-high
req_i  in  1  bus request, valid for one cycle
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_W  byte address; bits [2:0] ignored
be_i  in  DATA_W/8  write byte enables
wdata_i  in  DATA_W  write data
rdata_o  out  DATA_W  read data, valid while ack_o = 1
ack_o  out  1  transaction complete
err_o  out  1  unmapped address; qualified by ack_o
gpio_io  inout  NR_GPIOS  pins
cs_o  out  1  output-update strobe
irq_o  out  1  level interrupt

Behaviour:
- Register map (index = addr_i[5:3]):
  - 0 DOUT (RW)
  - 1 DIR (RW; 1 = output)
  - 2 DIN (RO; writes ignored, ack without err)
  - 3 IRQ_EN (RW)
  - 4 IRQ_STAT (read; write-1-to-clear)
  - 5..7 unmapped
- Bits at positions >= NR_GPIOS are not stored and read as 0.
- Reset (rst_i = 1 at a rising edge): DOUT, DIR, IRQ_EN, IRQ_STAT, the sync flops, rdata_o, ack_o, err_o, cs_o and irq_o all go to 0. All pins are high-Z.
- Bus handshake:
  - A request sampled at edge N gives ack_o = 1 for exactly the cycle after edge N. Latency is 1 and there is no back-pressure.
  - Back-to-back requests on consecutive cycles are each acked.
  - Writes take effect at the same edge that raises ack_o.
  - rdata_o is registered and returns the register value before any same-edge update.
  - When ack_o = 0, rdata_o = 0.
- Unmapped address: ack_o = 1 and err_o = 1 in the same cycle, rdata_o = 0, no state change, no cs_o.
- Byte enables: only bytes with be_i = 1 update RW registers. For IRQ_STAT, only enabled bytes clear bits.
- Pin drive: gpio_io[i] = DOUT[i] when DIR[i] = 1, else 'z. The drive is combinational from the registers.
- cs_o:
  - Asserted for exactly one cycle, coincident with ack_o, for any accepted write to DOUT with at least one be_i bit set.
  - DOUT already holds the new value during that cycle, so a sampler at the negedge sees the updated pins.
  - A write whose data equals the current DOUT still pulses cs_o.
  - Back-to-back DOUT writes produce cs_o high for consecutive cycles.
- Input path: 2-flop synchroniser sync1 -> sync2. DIN = sync2. Latency from a pin change to DIN is 2 edges.
- Edge detect:
  - A third flop prev holds the previous sync2.
  - rise[i] = sync2[i] & ~prev[i] & IRQ_EN[i] sets IRQ_STAT[i].
  - If a set and a W1C clear of the same bit occur in the same cycle, the set wins.
  - Bits already set stay set until cleared.
- irq_o is registered: irq_o = |(IRQ_STAT & IRQ_EN), one cycle after IRQ_STAT changes. Clearing IRQ_EN masks irq_o without clearing IRQ_STAT.
- Reset during a transaction: the pending ack_o and cs_o are dropped and the write is lost.
- Output pins also feed the synchroniser, so loopback edges are detected.

Decomposition:
- as_pack holds:
  - nr_gpios and gpio_addr_width (existing)
  - new localparams GPIO_DOUT_IDX = 0, GPIO_DIR_IDX = 1, GPIO_DIN_IDX = 2, GPIO_IEN_IDX = 3, GPIO_ISTAT_IDX = 4
  - typedef enum gpio_reg_e over these indices
- One sub-module, as_gpio_sync: parameterised NR_GPIOS-wide 2-flop synchroniser plus prev flop. It outputs din and rise with synchronous active-high reset.
- Register decode, bus handshake, cs_o and irq_o stay in as_gpio_ctrl.

Test Plan:
- Reset, then read DIN with pins undriven by the bench → ack_o 1 cycle after req, rdata_o = 0, err_o = 0, gpio_io all 'z.
- Write DIR = 0xFF, then DOUT = 0x80 with be = 0x01 → cs_o high exactly 1 cycle, coincident with ack_o; gpio_io = 0x80 at that cycle's negedge. Next cycle cs_o = 0.
- Write DOUT = 0x1234 with be = 0x02 while DOUT = 0x05 → DOUT = 0x05 (bit 8+ beyond NR_GPIOS = 8 dropped, byte 0 untouched), cs_o still pulses.
- DIR = 0, IRQ_EN = 0x01, bench drives pin0 0→1 → DIN[0] = 1 after 2 edges, IRQ_STAT = 0x01 at edge 3, irq_o = 1 at edge 4. Write IRQ_STAT = 0x01 → irq_o falls 1 cycle after the ack.
- W1C clear of IRQ_STAT[0] in the same cycle as a new rise on pin0 → IRQ_STAT[0] stays 1.
- Read addr 0x30 → ack_o = 1, err_o = 1, rdata_o = 0. Write DOUT then assert rst_i on the request cycle → no ack_o, no cs_o, DOUT = 0.
